enc_bind_ctrl: RTL

Sequencing controller for the encoder binder stage. It accepts one sample request and walks the encoder's binder packs one at a time. For each pack it issues a level-HV read, fires `start_encoding` with a one-hot pack enable, waits out the binder latency, then offers the pack's shifted HVs to the accumulator under valid/ready. It sits between the sample front-end, the level-HV memory, the binder packs and the bundling accumulator.

---
 rtl/enc_bind_ctrl_if.sv | 54 +++++
 rtl/enc_bind_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/enc_bind_ctrl_if.sv
// ---------------------------------------------------------------------------
// enc_bind_ctrl_if
// Bundles every non-clock, non-reset signal of the encoder binder sequencing
// controller so the sample front-end, level memory, binder packs and
// accumulator connections travel as one port.
//
// Signals (controller view, modport master):
//   in : clear, sample_valid, acc_ready
//   out: sample_ready, lvl_rd_en, lvl_pack_idx[PW], start_encoding,
//        pack_en[NUM_PACKS], acc_valid, acc_pack_idx[PW], acc_last,
//        busy, done
//   out (ENC_BIND_CTRL_PERF_EN only): perf_cycles[32], perf_stalls[16]
// The slave modport is the mirror image, for the surrounding logic.
// ---------------------------------------------------------------------------
interface enc_bind_ctrl_if #(
  parameter int NUM_PACKS = 4,
  parameter int PW        = $clog2(NUM_PACKS)
);
  logic                 clear;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 lvl_rd_en;
  logic [PW-1:0]        lvl_pack_idx;
  logic                 start_encoding;
  logic [NUM_PACKS-1:0] pack_en;
  logic                 acc_valid;
  logic                 acc_ready;
  logic [PW-1:0]        acc_pack_idx;
  logic                 acc_last;
  logic                 busy;
  logic                 done;
`ifdef ENC_BIND_CTRL_PERF_EN
  logic [31:0]          perf_cycles;
  logic [15:0]          perf_stalls;
`endif

  modport master (
    input  clear, sample_valid, acc_ready,
    output sample_ready, lvl_rd_en, lvl_pack_idx, start_encoding, pack_en,
           acc_valid, acc_pack_idx, acc_last, busy, done
`ifdef ENC_BIND_CTRL_PERF_EN
    , output perf_cycles, perf_stalls
`endif
  );

  modport slave (
    output clear, sample_valid, acc_ready,
    input  sample_ready, lvl_rd_en, lvl_pack_idx, start_encoding, pack_en,
           acc_valid, acc_pack_idx, acc_last, busy, done
`ifdef ENC_BIND_CTRL_PERF_EN
    , input perf_cycles, perf_stalls
`endif
  );
endinterface

// File: rtl/enc_bind_ctrl.sv
// ---------------------------------------------------------------------------
// enc_bind_ctrl
// Sequencing controller for the encoder binder stage. Accepts one sample,
// then for each binder pack: reads its level HVs (FETCH), pulses
// start_encoding with a one-hot pack enable (BIND), waits out the binder
// latency (WAIT) and offers the shifted HVs to the accumulator under
// valid/ready (EMIT). A one-cycle done pulse (DONE) closes the sample.
//
// Ports:
//   clk  - single clock
//   nrst - asynchronous active-low reset
//   bus  - enc_bind_ctrl_if.master (handshakes, strobes, status)
//
// Optional feature macro: ENC_BIND_CTRL_PERF_EN adds perf_cycles and
// perf_stalls counters to the interface; sequencing is identical either way.
//
// All outputs are decoded from registered state, so nothing combinational
// runs from acc_ready or sample_valid to an output.
// ---------------------------------------------------------------------------
module enc_bind_ctrl #(
  parameter int NUM_PACKS = 4,
  parameter int FETCH_LAT = 1,
  parameter int BIND_LAT  = 2,
  parameter int PW        = $clog2(NUM_PACKS)
) (
  input logic             clk,
  input logic             nrst,
  enc_bind_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_BIND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // The wait counter only has to reach max(FETCH_LAT, BIND_LAT) - 1.
  localparam int              MAX_LAT   = (FETCH_LAT > BIND_LAT) ? FETCH_LAT : BIND_LAT;
  localparam int              CW        = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0]   FETCH_END = CW'(FETCH_LAT - 1);
  localparam logic [CW-1:0]   WAIT_END  = CW'(BIND_LAT - 1);
  localparam logic [PW-1:0]   LAST_IDX  = PW'(NUM_PACKS - 1);
  localparam logic [NUM_PACKS-1:0] ONE_HOT0 = {{(NUM_PACKS-1){1'b0}}, 1'b1};

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state logic. clear overrides everything, including an accept in
  // IDLE, and drops the sample without a done pulse. The counter restarts
  // at zero on every state entry so each timed state counts from 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (bus.clear) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.sample_valid) begin
            state_d = S_FETCH;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
        S_FETCH: begin
          if (cnt_q == FETCH_END) begin
            state_d = S_BIND;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BIND: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (cnt_q == WAIT_END) begin
            state_d = S_EMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (bus.acc_ready) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FETCH;
              idx_d   = idx_q + 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, pack index and wait counter registers; reset lands in IDLE so a
  // sample interrupted by reset is never resumed.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode. The read strobe is only in the first FETCH cycle; the
  // index outputs are zeroed outside the states that qualify them.
  assign bus.sample_ready   = (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.lvl_rd_en      = (state_q == S_FETCH) && (cnt_q == '0);
  assign bus.lvl_pack_idx   = (state_q == S_FETCH) ? idx_q : '0;
  assign bus.start_encoding = (state_q == S_BIND);
  assign bus.pack_en        = (state_q == S_BIND) ? (ONE_HOT0 << idx_q) : '0;
  assign bus.acc_valid      = (state_q == S_EMIT);
  assign bus.acc_pack_idx   = (state_q == S_EMIT) ? idx_q : '0;
  assign bus.acc_last       = (state_q == S_EMIT) && (idx_q == LAST_IDX);
  assign bus.done           = (state_q == S_DONE);

`ifdef ENC_BIND_CTRL_PERF_EN
  logic        accept;
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_stalls_q;

  assign accept = (state_q == S_IDLE) && bus.sample_valid && !bus.clear;

  // Performance counters. perf_cycles counts every busy cycle, so after
  // DONE it holds accept-exclusive to done-inclusive and freezes in IDLE
  // until the next accept. perf_stalls counts EMIT cycles refused by the
  // accumulator. Both saturate rather than wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (bus.clear || accept) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if ((state_q != S_IDLE) && (perf_cycles_q != '1))
        perf_cycles_q <= perf_cycles_q + 1'b1;
      if ((state_q == S_EMIT) && !bus.acc_ready && (perf_stalls_q != '1))
        perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule
